// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// common to the receiver and the transmitter.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value is a
// parameter so idle-high lines come out of reset in their idle level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver paced by the shared oversampling tick strobe.
//   state | meaning
//   IDLE  | line idle, waiting for a tick that sees rx_s low
//   START | counting to the middle of the start bit to confirm it
//   DATA  | sampling data bits mid-bit, LSB first
//   STOP  | sampling the stop bit; done or framing error
//   BREAK | line held low after a framing error; wait for it to return high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TICK_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W  = cnt_width(DATA_BITS);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  logic rx_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx),
    .q_o(rx_s)
  );

  rx_state_e            state_q,    state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 done_q,     done_d;
  logic                 err_q,      err_d;
  logic                 busy_q,     busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (tick && !rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A high line at mid start bit was only a glitch.
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = rx_s;
            tick_cnt_d             = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            // Leaving mid stop bit lets a back-to-back start edge be caught.
            if (rx_s) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      ST_BREAK: begin
        tick_cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_rx_data   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// corner sequences, with a scoreboard of expected done/error pulses.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int CLK_NS = 10;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          rx   = 1'b1;
  logic          tick = 1'b0;
  logic [DB-1:0] o_rx_data;
  logic          o_rx_done;
  logic          o_frame_err;
  logic          o_busy;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int tick_div  = 4;
  int done_cyc  = -1;
  int start_cyc = 0;

  typedef struct {
    logic          is_err;
    logic [DB-1:0] data;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            gap;
    logic          exp_err;
    logic [DB-1:0] exp_data;
    logic          exp_busy;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  uart_rx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tick       (tick),
    .o_rx_data  (o_rx_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (tick_div <= 1) begin
        tick = 1'b1;
      end else begin
        t    = (t + 1) % tick_div;
        tick = (t == 0);
      end
    end
  end

  initial begin
    #(CLK_NS * 50000);
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic is_err, input logic [DB-1:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb_q.push_back(e);
  endtask

  // Monitor: every done/error pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (o_rx_done || o_frame_err) begin
      if (o_rx_done) done_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, o_rx_done, o_frame_err}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", {30'b0, o_rx_done, o_frame_err}, mon_e.is_err ? 32'h1 : 32'h2);
        check("pulse_data", o_rx_data, mon_e.data);
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    rx = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    @(negedge clk);
    rx        = 1'b0;
    start_cyc = cyc;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) send_bit(d[i], OS);
    send_bit(stop, OS);
  endtask

  initial begin
    int lows;
    int k;
    int lat;
    logic [DB-1:0] abort_byte;

    //          data   stop  gap err   exp_data busy-after-stop
    vecs[0] = '{8'h55, 1'b1, 4, 1'b0, 8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 4, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 4, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 2, 1'b0, 8'h81, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 4, 1'b0, 8'h55, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", o_rx_data, 32'h0);
    check("reset_done", o_rx_done, 32'h0);
    check("reset_err", o_frame_err, 32'h0);
    check("reset_busy", o_busy, 32'h0);
    rst = 1'b0;
    wait_ticks(4);

    for (int i = 0; i < 6; i++) begin
      expect_pulse(vecs[i].exp_err, vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop);
      #1;
      check($sformatf("vec%0d_data", i), o_rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), o_busy, vecs[i].exp_busy);
      if (vecs[i].gap > 0) send_bit(1'b1, vecs[i].gap);
    end

    // Framing error followed by a long break; data must stay at 0x55.
    expect_pulse(1'b1, 8'h55);
    send_frame(8'hA3, 1'b0);
    lows = 0;
    repeat (40) begin
      wait_ticks(1);
      #1;
      if (o_busy !== 1'b1) lows++;
    end
    check("break_busy_drops", lows, 32'h0);
    check("break_data_held", o_rx_data, 8'h55);
    @(negedge clk);
    rx = 1'b1;
    k  = 0;
    while (o_busy === 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("break_exit_busy", o_busy, 32'h0);
    send_bit(1'b1, 4);
    expect_pulse(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    #1;
    check("after_break_data", o_rx_data, 8'h3C);
    send_bit(1'b1, 4);

    // Short low glitch: detected, then rejected at mid start bit.
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    #1;
    check("glitch_busy_seen", o_busy, 32'h1);
    @(negedge clk);
    rx = 1'b1;
    k  = 0;
    while (o_busy === 1'b1 && k < (OS / 2 + 3)) begin
      wait_ticks(1);
      #1;
      k++;
    end
    check("glitch_busy_clear", o_busy, 32'h0);
    check("glitch_data_held", o_rx_data, 8'h3C);
    send_bit(1'b1, OS);

    // Reset during data bit 3 of 0x96 aborts silently.
    abort_byte = 8'h96;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) send_bit(abort_byte[i], OS);
    send_bit(abort_byte[3], OS / 2);
    #1;
    check("abort_busy_before", o_busy, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_data", o_rx_data, 32'h0);
    check("abort_done", o_rx_done, 32'h0);
    check("abort_err", o_frame_err, 32'h0);
    check("abort_busy", o_busy, 32'h0);
    send_bit(1'b1, 2 * (DB + 2) * OS);
    check("abort_idle_busy", o_busy, 32'h0);
    expect_pulse(1'b0, 8'h96);
    send_frame(8'h96, 1'b1);
    #1;
    check("after_abort_data", o_rx_data, 8'h96);
    send_bit(1'b1, 4);

    // Tick every clock: start edge to done is 9.5 bits plus sync and detect.
    tick_div = 1;
    send_bit(1'b1, 8);
    done_cyc = -1;
    expect_pulse(1'b0, 8'hC7);
    send_frame(8'hC7, 1'b1);
    #1;
    check("fast_data", o_rx_data, 8'hC7);
    lat = done_cyc - start_cyc;
    n_cmp++;
    if (lat < (9 * OS + OS / 2 + 3) - 3 || lat > (9 * OS + OS / 2 + 3) + 3) begin
      n_bad++;
      $display("FAIL fast_latency: got %0d clocks, want %0d +/- 3", lat, 9 * OS + OS / 2 + 3);
    end

    send_bit(1'b1, 8);
    check("scoreboard_empty", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
